// File: rtl/gpio_wr_arbiter.sv
// Two-requester round-robin write arbiter for the GPIO/LED device, with a shadow copy of the last word.
// Latency: strobe and ack come 1 cycle after a request is sampled in IDLE; shadow and wr_count follow 1 cycle later.
// Backpressure: requests are ignored in WRITE and GAP and must be held until ack; each write is followed by GAP_CYCLES idle cycles.
module gpio_wr_arbiter #(
   parameter int unsigned GAP_CYCLES  = 2,
   parameter logic [31:0] SHADOW_INIT = 32'h0000_02A8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        gpio_we,
   output logic [31:0] gpio_wdata,
   output logic [31:0] shadow,
   output logic [15:0] wr_count,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // GAP counts down from GAP_CYCLES-1 to 0, so it occupies exactly GAP_CYCLES cycles.
   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t      state_q, state_d;
   logic        gpio_we_q, gpio_we_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic [31:0] gpio_wdata_q, gpio_wdata_d;
   logic [31:0] shadow_q, shadow_d;
   logic [15:0] wr_count_q, wr_count_d;
   logic        last_grant_q, last_grant_d;
   logic [3:0]  gap_cnt_q, gap_cnt_d;
   logic        grant1;

   // Next-state logic: arbitrate in IDLE, commit in WRITE, count down in GAP.
   always_comb begin
      state_d      = state_q;
      gpio_we_d    = 1'b0;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      gpio_wdata_d = gpio_wdata_q;
      shadow_d     = shadow_q;
      wr_count_d   = wr_count_q;
      last_grant_d = last_grant_q;
      gap_cnt_d    = gap_cnt_q;
      // Requester 1 wins when it is alone, or on a tie when requester 0 had the last grant.
      grant1       = req1 && (!req0 || !last_grant_q);
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               state_d      = ST_WRITE;
               gpio_we_d    = 1'b1;
               ack0_d       = !grant1;
               ack1_d       = grant1;
               gpio_wdata_d = grant1 ? wdata1 : wdata0;
               last_grant_d = grant1;
            end
         end
         ST_WRITE: begin
            shadow_d   = gpio_wdata_q;
            wr_count_d = wr_count_q + 16'd1;
            if (GAP_CYCLES > 0) begin
               state_d   = ST_GAP;
               gap_cnt_d = GAP_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset cancels any in-flight write immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         gpio_we_q    <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         gpio_wdata_q <= 32'h0;
         shadow_q     <= SHADOW_INIT;
         wr_count_q   <= 16'h0;
         last_grant_q <= 1'b1;
         gap_cnt_q    <= 4'd0;
      end else begin
         state_q      <= state_d;
         gpio_we_q    <= gpio_we_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         gpio_wdata_q <= gpio_wdata_d;
         shadow_q     <= shadow_d;
         wr_count_q   <= wr_count_d;
         last_grant_q <= last_grant_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   assign gpio_we    = gpio_we_q;
   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign gpio_wdata = gpio_wdata_q;
   assign shadow     = shadow_q;
   assign wr_count   = wr_count_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpio_wr_arbiter.sv
// Bench for gpio_wr_arbiter: directed requests, expected writes queued and checked by a monitor.
// Latency: expected strobe cycles are stated per request relative to a free-running cycle count.
// Backpressure: requests are held until ack; gap blocking and a GAP_CYCLES=0 instance are covered.
module tb_gpio_wr_arbiter;

   localparam int          GAP  = 2;
   localparam logic [31:0] INIT = 32'h0000_02A8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [31:0] wdata0, wdata1;
   logic        ack0, ack1, gpio_we, busy;
   logic [31:0] gpio_wdata, shadow;
   logic [15:0] wr_count;

   logic        req0_b;
   logic [31:0] wdata0_b;
   logic        ack0_b, ack1_b, gpio_we_b, busy_b;
   logic [31:0] gpio_wdata_b, shadow_b;
   logic [15:0] wr_count_b;

   always #5 clk = ~clk;

   gpio_wr_arbiter #(.GAP_CYCLES(GAP), .SHADOW_INIT(INIT)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .gpio_we(gpio_we), .gpio_wdata(gpio_wdata),
      .shadow(shadow), .wr_count(wr_count), .busy(busy)
   );

   gpio_wr_arbiter #(.GAP_CYCLES(0), .SHADOW_INIT(INIT)) dut0 (
      .clk(clk), .rst(rst), .req0(req0_b), .req1(1'b0), .wdata0(wdata0_b), .wdata1(32'h0),
      .ack0(ack0_b), .ack1(ack1_b), .gpio_we(gpio_we_b), .gpio_wdata(gpio_wdata_b),
      .shadow(shadow_b), .wr_count(wr_count_b), .busy(busy_b)
   );

   typedef struct {
      int          who;
      logic [31:0] data;
      int          exp_cyc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          c0;
   logic [15:0] m_count;
   logic [31:0] m_shadow;
   logic        post_pend = 1'b0;
   logic [31:0] post_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the expected write on every strobe, then checks shadow/wr_count one cycle later.
   always @(negedge clk) begin
      if (rst) begin
         m_count   = 16'h0;
         m_shadow  = INIT;
         post_pend = 1'b0;
      end else begin
         if (post_pend) begin
            m_count   = m_count + 16'd1;
            m_shadow  = post_data;
            chk("shadow", shadow, m_shadow);
            chk("wr_count", 32'(wr_count), 32'(m_count));
            post_pend = 1'b0;
         end
         if (gpio_we) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got wdata %h at cycle %0d, expected no write", gpio_wdata, cyc);
            end else begin
               e = sb_q.pop_front();
               chk("gpio_wdata", gpio_wdata, e.data);
               chk("ack0", 32'(ack0), 32'(e.who == 0));
               chk("ack1", 32'(ack1), 32'(e.who == 1));
               chk("strobe_cycle", 32'(cyc), 32'(e.exp_cyc));
            end
            post_pend = 1'b1;
            post_data = gpio_wdata;
         end else begin
            chk("ack_without_we", 32'({ack0, ack1}), 32'h0);
         end
      end
   end

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wdata0 = 32'h0; wdata1 = 32'h0;
      req0_b = 1'b0; wdata0_b = 32'h0;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      chk("rst_gpio_we", 32'(gpio_we), 32'h0);
      chk("rst_acks", 32'({ack0, ack1}), 32'h0);
      chk("rst_gpio_wdata", gpio_wdata, 32'h0);
      chk("rst_shadow", shadow, 32'h0000_02A8);
      chk("rst_wr_count", 32'(wr_count), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      tick();

      // Single request from requester 0
      wdata0 = 32'h1234_5678; req0 = 1'b1;
      sb_q.push_back('{0, 32'h1234_5678, cyc + 1});
      tick();
      req0 = 1'b0;
      chk("busy_in_write", 32'(busy), 32'h1);
      tick();
      chk("busy_in_gap", 32'(busy), 32'h1);
      repeat (4) tick();

      // Requester 1 raised during requester 0's WRITE waits out the gap
      wdata0 = 32'hCAFE_0001; req0 = 1'b1;
      sb_q.push_back('{0, 32'hCAFE_0001, cyc + 1});
      tick();
      req0 = 1'b0;
      wdata1 = 32'hBEEF_0002; req1 = 1'b1;
      sb_q.push_back('{1, 32'hBEEF_0002, cyc + GAP + 2});
      repeat (GAP + 2) tick();
      req1 = 1'b0;
      repeat (GAP + 2) tick();

      // Request withdrawn before it is ever sampled in IDLE: no write
      wdata0 = 32'h1111_0003; req0 = 1'b1;
      sb_q.push_back('{0, 32'h1111_0003, cyc + 1});
      tick();
      req0 = 1'b0;
      tick();
      wdata1 = 32'hDEAD_0004; req1 = 1'b1;
      tick();
      req1 = 1'b0;
      repeat (4) tick();
      chk("viol_busy", 32'(busy), 32'h0);
      chk("viol_wr_count", 32'(wr_count), 32'h4);
      chk("viol_shadow", shadow, 32'h1111_0003);

      // Counter wrap from 16'hFFFF
      force dut.wr_count_q = 16'hFFFF;
      m_count = 16'hFFFF;
      tick();
      release dut.wr_count_q;
      tick();
      chk("preload", 32'(wr_count), 32'h0000_FFFF);
      wdata1 = 32'h0F0F_0F0F; req1 = 1'b1;
      sb_q.push_back('{1, 32'h0F0F_0F0F, cyc + 1});
      tick();
      req1 = 1'b0;
      repeat (4) tick();
      chk("wrap_wr_count", 32'(wr_count), 32'h0);

      // Both requests held from reset: order 0,1,0,1 with GAP+1 idle cycles between strobes
      rst = 1'b1;
      wdata0 = 32'hA0A0_0001; wdata1 = 32'hB1B1_0002; req0 = 1'b1; req1 = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      c0 = cyc;
      sb_q.push_back('{0, 32'hA0A0_0001, c0 + 1});
      sb_q.push_back('{1, 32'hB1B1_0002, c0 + 1 + (GAP + 2)});
      sb_q.push_back('{0, 32'hA0A0_0001, c0 + 1 + 2 * (GAP + 2)});
      sb_q.push_back('{1, 32'hB1B1_0002, c0 + 1 + 3 * (GAP + 2)});
      repeat (1 + 3 * (GAP + 2)) tick();
      req0 = 1'b0; req1 = 1'b0;
      repeat (GAP + 3) tick();
      chk("tie_wr_count", 32'(wr_count), 32'h4);

      // Reset during WRITE cancels the write asynchronously
      wdata0 = 32'h5555_AAAA; req0 = 1'b1;
      tick();
      #1;
      chk("pre_rst_we", 32'(gpio_we), 32'h1);
      chk("pre_rst_ack0", 32'(ack0), 32'h1);
      rst = 1'b1;
      #1;
      chk("midrst_we", 32'(gpio_we), 32'h0);
      chk("midrst_acks", 32'({ack0, ack1}), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_shadow", shadow, 32'h0000_02A8);
      chk("midrst_wr_count", 32'(wr_count), 32'h0);
      req0 = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_shadow", shadow, 32'h0000_02A8);

      // GAP_CYCLES=0 instance: continuous req0 strobes every 2nd cycle
      wdata0_b = 32'h7777_0005; req0_b = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("gap0_we", 32'(gpio_we_b), 32'(k % 2));
         chk("gap0_ack0", 32'(ack0_b), 32'(k % 2));
         chk("gap0_ack1", 32'(ack1_b), 32'h0);
         if (k == 7) req0_b = 1'b0;
      end
      tick();
      chk("gap0_wr_count", 32'(wr_count_b), 32'h4);
      chk("gap0_shadow", shadow_b, 32'h7777_0005);

      chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_wr_arbiter.md
GPIO_WR_ARBITER -- requirements
Module: gpio_wr_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2: idle cycles forced after each GPIO write before the next grant (legal range 0..15).
REQ-002 SHALL have parameter SHADOW_INIT, default 32'h0000_02A8: shadow reset value, matching the LED device reset word (LED=8'hAA at bits [9:2], all other fields 0).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports req0 / req1, input, 1 each: write request from requester 0 (CPU store path) / requester 1 (polling sequencer).
REQ-006 SHALL have ports wdata0 / wdata1, input, 32 each: write word {GPIOf0[21:0], LED[7:0], counter_set[1:0]} from each requester.
REQ-007 SHALL have ports ack0 / ack1, output, 1 each: one-cycle write-complete pulse to each requester.
REQ-008 SHALL have port gpio_we, output, 1: write strobe to the GPIO/LED device.
REQ-009 SHALL have port gpio_wdata, output, 32: registered write word to the device.
REQ-010 SHALL have port shadow, output, 32: copy of the last word written to the device.
REQ-011 SHALL have port wr_count, output, 16: count of completed writes.
REQ-012 SHALL have port busy, output, 1: high when the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, WRITE and GAP.
REQ-014 SHALL go from IDLE to WRITE on a posedge where req0 or req1 is high; otherwise IDLE SHALL hold.
REQ-015 SHALL grant by round robin: with one request, grant that requester; with both, grant the requester not granted last; last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-016 SHALL capture the granted wdata into gpio_wdata on the IDLE->WRITE edge; gpio_wdata SHALL hold its value outside that edge.
REQ-017 SHALL hold gpio_we high for exactly the one WRITE cycle, and assert ack of the granted requester in that same cycle; the other ack SHALL stay low.
REQ-018 SHALL give a latency of 1 cycle from a req sampled in IDLE to gpio_we/ack.
REQ-019 SHALL load gpio_wdata into shadow, and increment wr_count modulo 2^16 (0xFFFF wraps to 0x0000), on the WRITE->next edge.
REQ-020 SHALL leave WRITE for GAP when GAP_CYCLES>0; GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; with GAP_CYCLES=0, WRITE SHALL go directly to IDLE.
REQ-021 SHALL ignore requests during WRITE and GAP; they are neither lost nor acked, and are arbitrated on the first IDLE sample.
REQ-022 SHALL require a requester to hold req and wdata stable until its ack; a req still high on the cycle after ack SHALL count as a new request.
REQ-023 SHALL, when a req deasserts before grant (protocol violation), generate no write and no ack.
REQ-024 SHALL drive busy as combinational (state != IDLE).

Reset
REQ-025 SHALL, while rst=1, immediately force: state=IDLE, gpio_we=0, ack0=ack1=0, gpio_wdata=0, shadow=SHADOW_INIT, wr_count=0, last_grant=1, gap counter=0.
REQ-026 SHALL treat rst asserted during WRITE as cancelling that write: gpio_we drops asynchronously, with no ack, no shadow update and no wr_count increment.
REQ-027 SHALL arbitrate normally from the first posedge after rst deasserts.

Verification
REQ-028 SHALL pass single request: req0=1 with wdata0=32'h1234_5678 in IDLE -> next cycle gpio_we=1, ack0=1, gpio_wdata=32'h1234_5678; the following cycle shadow=32'h1234_5678 and wr_count=1.
REQ-029 SHALL pass tie arbitration: req0 and req1 held high from reset -> writes in order 0,1,0,1, with every gpio_we pulse separated by exactly GAP_CYCLES+1 low cycles (default 3).
REQ-030 SHALL pass gap blocking: req1 asserted in the WRITE cycle of requester 0 -> gpio_we for requester 1 appears exactly GAP_CYCLES+2 cycles after the requester 0 strobe.
REQ-031 SHALL pass counter wrap: force 65535 writes (or preload wr_count to 16'hFFFF), then one write -> wr_count=16'h0000.
REQ-032 SHALL pass reset mid-write: assert rst during the WRITE cycle -> gpio_we and ack fall without waiting for a clock edge; shadow=32'h0000_02A8; wr_count=0; busy=0.
REQ-033 SHALL pass GAP_CYCLES=0 build: continuous req0 -> gpio_we pulses every 2nd cycle, and ack0 is aligned with every pulse.
